// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - EX/MEM-side bundle into the data-memory access stage
interface mem_access_stage_if;
    logic [1:0]  WB;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [31:0] ALU_Result;
    logic [31:0] WriteData;
    logic [1:0]  WB_out;
    logic [31:0] MemReadData;
    logic        stall;
    logic        addr_err;

    modport master (
        output WB, MemRead, MemWrite, MemSize, MemUnsigned, ALU_Result, WriteData,
        input  WB_out, MemReadData, stall, addr_err
    );

    modport slave (
        input  WB, MemRead, MemWrite, MemSize, MemUnsigned, ALU_Result, WriteData,
        output WB_out, MemReadData, stall, addr_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - multi-cycle data-memory access stage with internal word RAM
module mem_access_stage #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_stage_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [31:0]             rd_q;
    logic [31:0]             mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   idx;
    logic [1:0]              lane;
    logic                    is_mem;
    logic                    misalign;
    logic                    illegal;
    logic                    req;
    logic [31:0]             word;
    logic [31:0]             shifted;
    logic [31:0]             ld_data;
    logic [31:0]             st_data;
    logic [3:0]              st_be;
    logic                    unused_addr_hi;

    assign idx            = bus.ALU_Result[DEPTH_LOG2+1:2];
    assign lane           = bus.ALU_Result[1:0];
    // Upper address bits are deliberately dropped so the RAM wraps.
    assign unused_addr_hi = ^bus.ALU_Result[31:DEPTH_LOG2+2];

    assign is_mem   = bus.MemRead | bus.MemWrite;
    assign misalign = ((bus.MemSize == 2'b10) && (lane != 2'b00)) ||
                      ((bus.MemSize == 2'b01) && lane[0]);
    assign illegal  = is_mem && ((bus.MemRead && bus.MemWrite) ||
                                 (bus.MemSize == 2'b11) || misalign);
    assign req      = is_mem && !illegal;

    // Load path: shift the addressed lane(s) down to bit 0, then extend.
    always_comb begin
        word    = mem[idx];
        shifted = word >> {lane, 3'b000};
        case (bus.MemSize)
            2'b00:   ld_data = bus.MemUnsigned ? {24'd0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = bus.MemUnsigned ? {16'd0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = word;
        endcase
    end

    // Store path: replicate the data across lanes and pick lanes with a byte enable.
    always_comb begin
        case (bus.MemSize)
            2'b00: begin
                st_data = {4{bus.WriteData[7:0]}};
                st_be   = 4'b0001 << lane;
            end
            2'b01: begin
                st_data = {2{bus.WriteData[15:0]}};
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = bus.WriteData;
                st_be   = 4'b1111;
            end
        endcase
    end

    // Sequencer: IDLE -> BUSY (counting) -> DONE -> IDLE; load data latched entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rd_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    rd_q <= 32'd0;
                    if (req) begin
                        if (LATENCY >= 2) begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= DONE;
                            rd_q  <= bus.MemRead ? ld_data : 32'd0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        rd_q  <= bus.MemRead ? ld_data : 32'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 32'd0;
                end
            endcase
        end
    end

    // Store commit on the edge leaving DONE; a reset on that edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && (state == DONE) && bus.MemWrite) begin
            for (int k = 0; k < 4; k++) begin
                if (st_be[k]) begin
                    mem[idx][8*k +: 8] <= st_data[8*k +: 8];
                end
            end
        end
    end

    // Outputs: stall and bubble while in flight, pass WB through otherwise.
    always_comb begin
        bus.stall    = 1'b0;
        bus.WB_out   = 2'b00;
        bus.addr_err = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    bus.addr_err = illegal;
                    bus.stall    = req;
                    bus.WB_out   = is_mem ? 2'b00 : bus.WB;
                end
                BUSY:    bus.stall  = 1'b1;
                default: bus.WB_out = bus.WB;
            endcase
        end
    end

    assign bus.MemReadData = rd_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_stage_if bus ();

    mem_access_stage #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  wb;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] wb);
        bus.MemRead     = rd;
        bus.MemWrite    = wr;
        bus.MemSize     = size;
        bus.MemUnsigned = uns;
        bus.ALU_Result  = addr;
        bus.WriteData   = wdata;
        bus.WB          = wb;
    endtask

    // Called just after a rising edge; returns just after the edge ending the instruction.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] wb, input logic [31:0] exp_data, input logic [1:0] exp_wb,
                          input logic exp_err, input int exp_stalls);
        exp_t e;
        exp_t got_e;
        int   stalls = 0;
        bit   done   = 0;
        drive(rd, wr, size, uns, addr, wdata, wb);
        e.data = exp_data; e.wb = exp_wb; e.err = exp_err; e.stalls = exp_stalls;
        exp_q.push_back(e);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.stall) begin
                stalls++;
                check_eq({tag, "_bubble_wb"}, {30'd0, bus.WB_out}, 32'd0);
                check_eq({tag, "_bubble_data"}, bus.MemReadData, 32'd0);
                @(posedge clk); #1;
            end else begin
                done = 1;
            end
        end
        if (!done) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        got_e = exp_q.pop_front();
        check_eq({tag, "_data"}, bus.MemReadData, got_e.data);
        check_eq({tag, "_wb"}, {30'd0, bus.WB_out}, {30'd0, got_e.wb});
        check_eq({tag, "_err"}, {31'd0, bus.addr_err}, {31'd0, got_e.err});
        check_eq({tag, "_stalls"}, 32'(stalls), 32'(got_e.stalls));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2'b11);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
            check_eq("rst_err", {31'd0, bus.addr_err}, 32'd0);
            check_eq("rst_wb", {30'd0, bus.WB_out}, 32'd0);
            check_eq("rst_data", bus.MemReadData, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("sw10",  0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2'b00, 32'h0,        2'b00, 0, LAT);
        run_op("lw10",  1, 0, 2'b10, 0, 32'h10, 32'h0,        2'b11, 32'hDEADBEEF, 2'b11, 0, LAT);
        run_op("sw20",  0, 1, 2'b10, 0, 32'h20, 32'h11223344, 2'b00, 32'h0,        2'b00, 0, LAT);
        run_op("sb23",  0, 1, 2'b00, 0, 32'h23, 32'h000000A5, 2'b00, 32'h0,        2'b00, 0, LAT);
        run_op("lw20a", 1, 0, 2'b10, 0, 32'h20, 32'h0,        2'b11, 32'hA5223344, 2'b11, 0, LAT);
        run_op("lb23",  1, 0, 2'b00, 0, 32'h23, 32'h0,        2'b01, 32'hFFFFFFA5, 2'b01, 0, LAT);
        run_op("lbu23", 1, 0, 2'b00, 1, 32'h23, 32'h0,        2'b11, 32'h000000A5, 2'b11, 0, LAT);
        run_op("lh22",  1, 0, 2'b01, 0, 32'h22, 32'h0,        2'b11, 32'hFFFFA522, 2'b11, 0, LAT);
        run_op("lhu22", 1, 0, 2'b01, 1, 32'h22, 32'h0,        2'b11, 32'h0000A522, 2'b11, 0, LAT);
        run_op("sh20",  0, 1, 2'b01, 0, 32'h20, 32'h0000BEEF, 2'b00, 32'h0,        2'b00, 0, LAT);
        run_op("lw20b", 1, 0, 2'b10, 0, 32'h20, 32'h0,        2'b11, 32'hA522BEEF, 2'b11, 0, LAT);

        run_op("ill_lw06",  1, 0, 2'b10, 0, 32'h06, 32'h0,        2'b11, 32'h0, 2'b00, 1, 0);
        run_op("ill_lh21",  1, 0, 2'b01, 0, 32'h21, 32'h0,        2'b11, 32'h0, 2'b00, 1, 0);
        run_op("ill_sz11",  0, 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 2'b11, 32'h0, 2'b00, 1, 0);
        run_op("ill_both",  1, 1, 2'b10, 0, 32'h20, 32'hFFFFFFFF, 2'b11, 32'h0, 2'b00, 1, 0);
        run_op("lw20c", 1, 0, 2'b10, 0, 32'h20, 32'h0,        2'b11, 32'hA522BEEF, 2'b11, 0, LAT);

        run_op("sw30",  0, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 2'b00, 32'h0, 2'b00, 0, LAT);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, 2'b00);
        @(negedge clk);
        check_eq("rstmid_c0_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        check_eq("rstmid_after_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        run_op("lw30",  1, 0, 2'b10, 0, 32'h30, 32'h0, 2'b11, 32'hCAFEF00D, 2'b11, 0, LAT);

        run_op("pass",  0, 0, 2'b10, 0, 32'h44, 32'h0, 2'b10, 32'h0, 2'b10, 0, 0);
        run_op("sw400", 0, 1, 2'b10, 0, 32'h400, 32'h55AA55AA, 2'b00, 32'h0, 2'b00, 0, LAT);
        run_op("lw0",   1, 0, 2'b10, 0, 32'h0,   32'h0,        2'b11, 32'h55AA55AA, 2'b11, 0, LAT);

        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
